rll_encode: RTL and testbench

RLL_ENCODE -- requirements
Module: rll_encode

---
 rtl/rll_encode.sv | 167 ++++++++++++++++
 tb/tb_rll_encode.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rll_encode.sv
// rll_encode: run-length-limited frame encoder.
// Scans a word of N base-4 digits MSD first.  Each run of four zero digits
// (greedy, non-overlapping) is removed from the data and replaced by a
// pointer.  The pointer records the run's start position.  Data is packed
// at the top of the M-digit frame.  Pointers sit at the bottom, each one as
// a 2'b01 marker followed by a 4-digit index.  A 2'b00 terminator follows
// the last pointer.
// Optional feature: define RLL_ENC_OVF_FLAG_EN to add output ovf.  ovf is
// set when a zero run could not be replaced because the pointer budget
// (M-N-1) was already used up.
// Handshake: a word is taken on a clock edge where in_valid && in_ready.
// A frame is delivered on a clock edge where out_valid && out_ready.
// While out_valid is 1 and out_ready is 0, word_out, out_len and out_ptrs
// are held unchanged.
module rll_encode #(
    parameter int N = 15,
    parameter int M = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   word_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*M-1:0]   word_out,
    output logic [7:0]       out_len,
    output logic [7:0]       out_ptrs
`ifdef RLL_ENC_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int MAXP = M - N - 1;
    localparam int PSZ  = (MAXP > 0) ? MAXP : 1;
    localparam int PW   = (PSZ > 1) ? $clog2(PSZ) : 1;
    localparam int AW   = $clog2(N);
    // A pointer field needs 5 frame digits, so no more than M/5 pointers fit.
    localparam int PLIM = (PSZ < M / 5) ? PSZ : M / 5;

    typedef enum logic [1:0] {IDLE, SCAN, BUILD, HOLD} state_t;

    state_t         state;
    logic [2*N-1:0] shreg;          // latched word; the current digit is at the top
    logic [7:0]     j;              // position of the digit being scanned
    logic [7:0]     wp;             // data accumulator write index
    logic [7:0]     r;              // pointers found so far
    logic [1:0]     z;              // consecutive zeros seen, saturating at 3
    logic [1:0]     acc   [N];      // compacted data digits, index 0 = MSD
    logic [7:0]     ptr_q [PSZ];    // pointer indices in discovery order
`ifdef RLL_ENC_OVF_FLAG_EN
    logic           ovf_seen;
`endif

    logic [1:0]     dig;
    logic           run_hit;
    logic           run_ovf;
    logic [2*M-1:0] frame;

    assign in_ready = (state == IDLE);
    assign dig      = shreg[2*N-1 -: 2];
    // The fourth zero in a row becomes a pointer only while pointers remain.
    assign run_hit  = (dig == 2'b00) && (z == 2'd3) && (int'(r) < MAXP);
    assign run_ovf  = (dig == 2'b00) && (z == 2'd3) && (int'(r) >= MAXP);

    // Assemble the frame from the data accumulator and the pointer list.
    always_comb begin
        frame = '0;
        for (int k = 0; k < N; k++) begin
            if (k < int'(wp)) begin
                frame[2*(M-1-k) +: 2] = acc[k];
            end
        end
        for (int k = 0; k < PLIM; k++) begin
            if (k < int'(r)) begin
                frame[10*k +: 2]     = 2'b01;
                frame[10*k + 2 +: 8] = ptr_q[k];
            end
        end
    end

    // Control FSM with the scan datapath and the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            j         <= '0;
            wp        <= '0;
            r         <= '0;
            z         <= '0;
            for (int i = 0; i < N; i++) acc[i] <= '0;
            for (int i = 0; i < PSZ; i++) ptr_q[i] <= '0;
            out_valid <= 1'b0;
            word_out  <= '0;
            out_len   <= '0;
            out_ptrs  <= '0;
`ifdef RLL_ENC_OVF_FLAG_EN
            ovf_seen  <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg    <= word_in;
                        j        <= '0;
                        wp       <= '0;
                        r        <= '0;
                        z        <= '0;
`ifdef RLL_ENC_OVF_FLAG_EN
                        ovf_seen <= 1'b0;
`endif
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    shreg <= shreg << 2;
                    j     <= j + 8'd1;
                    if (run_hit) begin
                        // Drop the three zeros already written; this one is not stored.
                        wp              <= wp - 8'd3;
                        ptr_q[r[PW-1:0]] <= j - 8'd3;
                        r               <= r + 8'd1;
                        z               <= 2'd0;
                    end else begin
                        acc[wp[AW-1:0]] <= dig;
                        wp              <= wp + 8'd1;
                        if (dig == 2'b00) begin
                            z <= (z == 2'd3) ? 2'd3 : z + 2'd1;
                        end else begin
                            z <= 2'd0;
                        end
`ifdef RLL_ENC_OVF_FLAG_EN
                        if (run_ovf) ovf_seen <= 1'b1;
`endif
                    end
                    if (j == 8'(N - 1)) state <= BUILD;
                end
                BUILD: begin
                    word_out  <= frame;
                    out_len   <= 8'(N + 1) + r;
                    out_ptrs  <= r;
                    out_valid <= 1'b1;
`ifdef RLL_ENC_OVF_FLAG_EN
                    ovf       <= ovf_seen;
`endif
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef RLL_ENC_OVF_FLAG_EN
    // Without the flag, an unreplaced run has no observer.
    logic unused_ovf;
    assign unused_ovf = run_ovf;
`endif

endmodule

// File: tb/tb_rll_encode.sv
// Directed bench for rll_encode.
// Instance a: N=15, M=20.  Instance b: N=20, M=22, which has a single
// pointer slot.  Both instances share clk and rst.
// Define RLL_ENC_OVF_FLAG_EN to include the ovf checks.
module tb_rll_encode;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- instance a (N=15, M=20) ----------------
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [29:0] a_word_in;
    logic [39:0] a_word_out;
    logic [7:0]  a_out_len, a_out_ptrs;
`ifdef RLL_ENC_OVF_FLAG_EN
    logic        a_ovf;
`endif

    rll_encode #(.N(15), .M(20)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .word_in(a_word_in),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .word_out(a_word_out),
        .out_len(a_out_len), .out_ptrs(a_out_ptrs)
`ifdef RLL_ENC_OVF_FLAG_EN
        , .ovf(a_ovf)
`endif
    );

    // ---------------- instance b (N=20, M=22) ----------------
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [39:0] b_word_in;
    logic [43:0] b_word_out;
    logic [7:0]  b_out_len, b_out_ptrs;
`ifdef RLL_ENC_OVF_FLAG_EN
    logic        b_ovf;
`endif

    rll_encode #(.N(20), .M(22)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .word_in(b_word_in),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .word_out(b_word_out),
        .out_len(b_out_len), .out_ptrs(b_out_ptrs)
`ifdef RLL_ENC_OVF_FLAG_EN
        , .ovf(b_ovf)
`endif
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Latency is counted in posedges, with the accepting edge counted as edge 1.
    // in_valid stays high with a different word during the scan.  That word
    // must be ignored.
    task automatic run_a(input logic [29:0] w, input logic [39:0] f, input logic [7:0] len,
                         input logic [7:0] ptrs, input logic ovf_e, input int stall);
        int          cyc;
        logic [63:0] exp;
        exp_q.push_back({24'h0, f});
        @(negedge clk);
        a_in_valid = 1'b1;
        a_word_in  = w;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        check("a_in_ready_busy", a_in_ready, 1'b0);
        a_word_in = ~w;
        while (!a_out_valid && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        a_in_valid = 1'b0;
        check("a_out_valid_timeout", a_out_valid, 1'b1);
        check("a_latency", cyc, 17);
        exp = exp_q.pop_front();
        check("a_word_out", a_word_out, exp);
        check("a_out_len", a_out_len, len);
        check("a_out_ptrs", a_out_ptrs, ptrs);
`ifdef RLL_ENC_OVF_FLAG_EN
        check("a_ovf", a_ovf, ovf_e);
`else
        if (ovf_e) $display("note: ovf expectation needs RLL_ENC_OVF_FLAG_EN");
`endif
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("a_stall_valid", a_out_valid, 1'b1);
            check("a_stall_word", a_word_out, exp);
            check("a_stall_len", a_out_len, len);
            check("a_stall_in_ready", a_in_ready, 1'b0);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        check("a_release_valid", a_out_valid, 1'b0);
        check("a_release_in_ready", a_in_ready, 1'b1);
    endtask

    task automatic run_b(input logic [39:0] w, input logic [43:0] f, input logic [7:0] len,
                         input logic [7:0] ptrs, input logic ovf_e);
        int          cyc;
        logic [63:0] exp;
        exp_q.push_back({20'h0, f});
        @(negedge clk);
        b_in_valid = 1'b1;
        b_word_in  = w;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        b_in_valid = 1'b0;
        while (!b_out_valid && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check("b_out_valid_timeout", b_out_valid, 1'b1);
        check("b_latency", cyc, 22);
        exp = exp_q.pop_front();
        check("b_word_out", b_word_out, exp);
        check("b_out_len", b_out_len, len);
        check("b_out_ptrs", b_out_ptrs, ptrs);
`ifdef RLL_ENC_OVF_FLAG_EN
        check("b_ovf", b_ovf, ovf_e);
`else
        if (ovf_e) $display("note: ovf expectation needs RLL_ENC_OVF_FLAG_EN");
`endif
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        check("b_release_valid", b_out_valid, 1'b0);
        check("b_release_in_ready", b_in_ready, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit seen;
        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_word_in = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_word_in = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", a_out_valid, 1'b0);
        check("rst_word_out", a_word_out, 40'h0);
        check("rst_out_len", a_out_len, 8'h0);
        check("rst_out_ptrs", a_out_ptrs, 8'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", a_in_ready, 1'b1);

        // All digits 11: no pointers; the word sits unchanged at the top.
        // The consumer stalls for 10 cycles.
        run_a({15{2'b11}}, {{15{2'b11}}, 10'h000}, 8'd16, 8'd0, 1'b0, 10);
        // Digits 2..5 zero: pointer p=2, 11 data digits of 10.
        run_a({2'b10, 2'b10, 8'h00, {9{2'b10}}},
              {{11{2'b10}}, 8'h00, 10'h009}, 8'd17, 8'd1, 1'b0, 0);
        // Five zeros: one pointer p=0; the fifth zero stays in the data.
        run_a({10'h000, {10{2'b01}}},
              {2'b00, {10{2'b01}}, 8'h00, 10'h001}, 8'd17, 8'd1, 1'b0, 0);
        // Eight zeros: pointers p=0 and p=4.
        run_a({16'h0000, {7{2'b11}}},
              {{7{2'b11}}, 6'b0, 10'h011, 10'h001}, 8'd18, 8'd2, 1'b0, 0);

        // One pointer slot: the first run becomes a pointer, the second stays.
        run_b({8'h00, {6{2'b11}}, 8'h00, {6{2'b11}}},
              {{6{2'b11}}, 8'h00, {6{2'b11}}, 2'b00, 10'h001}, 8'd22, 8'd1, 1'b1);

        // Reset during scan cycle 7: nothing is presented afterwards.
        @(negedge clk);
        a_in_valid = 1'b1;
        a_word_in  = {15{2'b10}};
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", a_out_valid, 1'b0);
        check("midrst_word_out", a_word_out, 40'h0);
        check("midrst_out_len", a_out_len, 8'h0);
        check("midrst_out_ptrs", a_out_ptrs, 8'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (a_out_valid) seen = 1'b1;
        end
        check("midrst_no_output", seen, 1'b0);
        check("midrst_in_ready", a_in_ready, 1'b1);

        // All zeros: pointers p=0, 4 and 8; three zero data digits remain.
        run_a(30'h0, {10'h000, 10'h021, 10'h011, 10'h001}, 8'd19, 8'd3, 1'b0, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
